// File: rtl/uart_pkg.sv
// Shared types and elaboration-time helpers for the UART baud-rate generator.
// Latency: none (types, constants and a constant function only).
// Backpressure: not applicable.
package uart_pkg;

  // Generator control states: stopped, running, or running with a divisor
  // update waiting for the current period to finish.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } baud_state_t;

  // Reset-time divisor split into integer and fractional parts.
  typedef struct packed {
    logic [31:0] int_part;
    logic [31:0] frac_part;
  } div_default_t;

  // D = sys_freq / (baud * os). The remainder is rounded to frac_width bits;
  // if rounding reaches a whole unit it is carried into the integer part.
  function automatic div_default_t calc_default_div(input int sys_freq,
                                                    input int baud,
                                                    input int os,
                                                    input int frac_width);
    longint unsigned den;
    longint unsigned ip;
    longint unsigned rem;
    longint unsigned fp;
    longint unsigned one;
    div_default_t    r;
    one = 64'd1;
    den = 64'(baud) * 64'(os);
    ip  = 64'(sys_freq) / den;
    rem = 64'(sys_freq) - ip * den;
    fp  = ((rem << frac_width) + den / 64'd2) / den;
    if (fp >= (one << frac_width)) begin
      ip = ip + 64'd1;
      fp = 64'd0;
    end
    r.int_part  = ip[31:0];
    r.frac_part = fp[31:0];
    return r;
  endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// Control/tick bundle between a UART engine (master) and the baud generator (slave).
// Ports: enable, div_int, div_frac, div_load, restart (master->slave);
//        div_ack, os_tick, bit_tick, tick_idx (slave->master). No flow control.
interface uart_baud_gen_if
  import uart_pkg::*;
#(
  parameter int C_DIV_WIDTH  = 16,
  parameter int C_FRAC_WIDTH = 4,
  parameter int C_OVERSAMPLE = 16
);
  logic                            enable;
  logic [C_DIV_WIDTH-1:0]          div_int;
  logic [C_FRAC_WIDTH-1:0]         div_frac;
  logic                            div_load;
  logic                            restart;
  logic                            div_ack;
  logic                            os_tick;
  logic                            bit_tick;
  logic [$clog2(C_OVERSAMPLE)-1:0] tick_idx;

  modport master (
    output enable, div_int, div_frac, div_load, restart,
    input  div_ack, os_tick, bit_tick, tick_idx
  );

  modport slave (
    input  enable, div_int, div_frac, div_load, restart,
    output div_ack, os_tick, bit_tick, tick_idx
  );
endinterface

// File: rtl/uart_baud_frac_acc.sv
// Fractional divisor accumulator: adds frac on each step, flags the overflow.
// Latency: carry is registered and valid the cycle after the step that produced it.
// Backpressure: none; clear has priority over step.
// Ports: Clk, Resetn (async, active-low), clear, step, frac, carry.
module uart_baud_frac_acc #(
  parameter int C_FRAC_WIDTH = 4
) (
  input  logic                    Clk,
  input  logic                    Resetn,
  input  logic                    clear,
  input  logic                    step,
  input  logic [C_FRAC_WIDTH-1:0] frac,
  output logic                    carry
);
  logic [C_FRAC_WIDTH-1:0] acc_q;
  logic [C_FRAC_WIDTH:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, frac};

  // carry holds until the next step, so it describes the most recent wrap.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      acc_q <= '0;
      carry <= 1'b0;
    end else if (clear) begin
      acc_q <= '0;
      carry <= 1'b0;
    end else if (step) begin
      acc_q <= sum[C_FRAC_WIDTH-1:0];
      carry <= sum[C_FRAC_WIDTH];
    end
  end
endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator: fractional divider producing oversample and bit ticks.
// Latency: os_tick registered, one cycle after the period counter wraps.
// Backpressure: none; enable low freezes all phase state in place.
// Ports: Clk, Resetn (async, active-low), bus (uart_baud_gen_if.slave).
// Build option: define UART_BAUD_FRAC_EN to add fractional accumulation;
// without it div_frac is ignored and every period is exactly div_int cycles.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int C_SYSTEM_FREQ = 100_000_000,
  parameter int C_BAUDRATE    = 115_200,
  parameter int C_OVERSAMPLE  = 16,   // power of two, 4..32
  parameter int C_DIV_WIDTH   = 16,
  parameter int C_FRAC_WIDTH  = 4
) (
  input  logic              Clk,
  input  logic              Resetn,
  uart_baud_gen_if.slave    bus
);
  localparam int TW = $clog2(C_OVERSAMPLE);
  localparam div_default_t DEF =
    calc_default_div(C_SYSTEM_FREQ, C_BAUDRATE, C_OVERSAMPLE, C_FRAC_WIDTH);
  localparam logic [C_DIV_WIDTH-1:0] DEF_INT = C_DIV_WIDTH'(DEF.int_part);
  localparam logic [C_DIV_WIDTH:0]   ONE_W   = (C_DIV_WIDTH+1)'(1);

  function automatic logic [C_DIV_WIDTH-1:0] clamp_int(input logic [C_DIV_WIDTH-1:0] v);
    return (v < C_DIV_WIDTH'(2)) ? C_DIV_WIDTH'(2) : v;
  endfunction

  baud_state_t            state_q, state_d;
  logic [C_DIV_WIDTH-1:0] int_q, sh_int_q, apply_int;
  logic [C_DIV_WIDTH:0]   cnt_q, period;
  logic [TW-1:0]          idx_q;
  logic                   os_q, bit_q, ack_q;
  logic                   carry, wrap;
  logic                   imm_load, flush_pend, bnd_apply, apply, sh_wr;

  // A load is taken immediately when the generator is (or is about to be)
  // stopped, or when a restart realigns phase anyway.
  assign imm_load   = bus.div_load && (state_q == IDLE || !bus.enable || bus.restart);
  // Stopping with an update still pending commits it so it is not lost.
  assign flush_pend = (state_q == PEND) && !bus.enable && !bus.div_load;
  assign bnd_apply  = (state_q == PEND) && wrap && !bus.restart;
  assign apply      = imm_load || flush_pend || bnd_apply;
  assign sh_wr      = bus.div_load && !imm_load;
  // A load landing on the boundary cycle supersedes the older shadow value.
  assign apply_int  = bus.div_load ? clamp_int(bus.div_int) : sh_int_q;

  // One extra bit so int+carry never overflows; >= keeps a shrunken divisor
  // from running the counter past its new end.
  assign period = {1'b0, int_q} + {{C_DIV_WIDTH{1'b0}}, carry};
  assign wrap   = bus.enable && (cnt_q >= period - ONE_W);

`ifdef UART_BAUD_FRAC_EN
  localparam logic [C_FRAC_WIDTH-1:0] DEF_FRAC = C_FRAC_WIDTH'(DEF.frac_part);
  logic [C_FRAC_WIDTH-1:0] frac_q, sh_frac_q, apply_frac;
  logic                    acc_step, acc_clear;

  assign apply_frac = bus.div_load ? bus.div_frac : sh_frac_q;
  assign acc_step   = wrap && !bus.restart;
  // A newly active divisor starts its fraction sequence from zero.
  assign acc_clear  = bus.restart || apply;

  uart_baud_frac_acc #(.C_FRAC_WIDTH(C_FRAC_WIDTH)) u_frac_acc (
    .Clk    (Clk),
    .Resetn (Resetn),
    .clear  (acc_clear),
    .step   (acc_step),
    .frac   (frac_q),
    .carry  (carry)
  );

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      frac_q    <= DEF_FRAC;
      sh_frac_q <= '0;
    end else begin
      if (sh_wr) sh_frac_q <= bus.div_frac;
      if (apply) frac_q    <= apply_frac;
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^bus.div_frac;
  assign carry       = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     if (bus.div_load && !bus.restart) state_d = PEND;
        PEND:    if ((bus.restart && bus.div_load) || bnd_apply) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      int_q    <= DEF_INT;
      sh_int_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      os_q     <= 1'b0;
      bit_q    <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      ack_q <= apply;
      if (sh_wr) sh_int_q <= clamp_int(bus.div_int);
      if (apply) int_q    <= apply_int;

      if (bus.restart) begin
        cnt_q <= '0;
        idx_q <= '0;
        os_q  <= 1'b0;
        bit_q <= 1'b0;
      end else if (wrap) begin
        cnt_q <= '0;
        idx_q <= idx_q + TW'(1);
        os_q  <= 1'b1;
        bit_q <= (idx_q == TW'(C_OVERSAMPLE - 1));
      end else begin
        if (bus.enable) cnt_q <= cnt_q + ONE_W;
        os_q  <= 1'b0;
        bit_q <= 1'b0;
      end
    end
  end

  assign bus.os_tick  = os_q;
  assign bus.bit_tick = bit_q;
  assign bus.div_ack  = ack_q;
  assign bus.tick_idx = idx_q;
endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: scoreboard of expected os_tick gaps, tick_idx,
// bit_tick and div_ack, filled as stimulus is applied and drained per tick.
// Expectations follow whichever build (UART_BAUD_FRAC_EN or not) is compiled.
module tb_uart_baud_gen;
  localparam int OS      = 16;
  localparam int EXP_INT = 54;   // 100e6 / (115200*16) = 54.25
`ifdef UART_BAUD_FRAC_EN
  localparam int EXP_FRAC = 4;   // 0.25 * 16
  localparam int EXP_BIT  = 868;
  localparam int IDLE_FRAC = 5;
`else
  localparam int EXP_FRAC = 0;
  localparam int EXP_BIT  = 864;
  localparam int IDLE_FRAC = 0;
`endif

  typedef struct packed {
    logic [15:0] gap;
    logic [7:0]  idx;
    logic        bt;
    logic        ack;
  } tick_t;

  logic Clk = 1'b0;
  logic Resetn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last = 0;
  int   acc_m = 0;
  bit   cy_m = 1'b0;
  int   idx_m = 0;
  tick_t sb[$];

  uart_baud_gen_if #(.C_DIV_WIDTH(16), .C_FRAC_WIDTH(4), .C_OVERSAMPLE(OS)) bus ();

  uart_baud_gen dut (
    .Clk    (Clk),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    acc_m = 0; cy_m = 1'b0; idx_m = 0;
  endtask

  // Reference period model: gap = int + carry-from-previous-wrap.
  task automatic push_ticks(input int n, input int per, input int frac,
                            input int extra, input bit ack0);
    tick_t e;
    int    s;
    for (int i = 0; i < n; i++) begin
      e.gap = 16'(per + int'(cy_m) + ((i == 0) ? extra : 0));
      s     = acc_m + frac;
      cy_m  = (s >= 16);
      acc_m = s % 16;
      idx_m = (idx_m + 1) % OS;
      e.idx = 8'(idx_m);
      e.bt  = (idx_m == 0);
      e.ack = (i == 0) ? ack0 : 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic wait_tick(input int budget, output int t, output bit ok,
                           output int n_ack, output int n_bt);
    ok = 1'b0; t = 0; n_ack = 0; n_bt = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (bus.os_tick) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
      if (bus.div_ack)  n_ack++;
      if (bus.bit_tick) n_bt++;
    end
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    Resetn = 1'b0;
    bus.enable = 1'b0; bus.div_load = 1'b0; bus.restart = 1'b0;
    bus.div_int = '0; bus.div_frac = '0;
    repeat (2) @(negedge Clk);
    Resetn = 1'b1;
    @(negedge Clk);
    model_reset();
    sb.delete();
  endtask

  task automatic test_reset();
    int seen;
    apply_reset();
    checks++;
    if ({bus.os_tick, bus.bit_tick, bus.div_ack, bus.tick_idx} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs: got os %0b bit %0b ack %0b idx %0d, expected all 0",
               bus.os_tick, bus.bit_tick, bus.div_ack, bus.tick_idx);
    end
    seen = 0;
    repeat (120) begin
      @(negedge Clk);
      if (bus.os_tick || bus.bit_tick || bus.div_ack) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_disabled_quiet: got %0d active cycles, expected 0", seen);
    end
  endtask

  task automatic test_default_rate();
    tick_t e, got;
    int t, na, nb;
    bit ok;
    int bts[$];
    apply_reset();
    bus.enable = 1'b1;
    last = cyc;
    push_ticks(32, EXP_INT, EXP_FRAC, 0, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      wait_tick(200, t, ok, na, nb);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL default_tick: no os_tick in 200 cycles, expected gap %0d", e.gap);
      end else begin
        got.gap = 16'(t - last); got.idx = 8'(bus.tick_idx);
        got.bt = bus.bit_tick; got.ack = bus.div_ack;
        if (got !== e) begin
          errors++;
          $display("FAIL default_tick: got gap %0d idx %0d bit %0b ack %0b, expected gap %0d idx %0d bit %0b ack %0b",
                   got.gap, got.idx, got.bt, got.ack, e.gap, e.idx, e.bt, e.ack);
        end
        if (bus.bit_tick) bts.push_back(t);
        last = t;
      end
    end
    checks++;
    if (bts.size() != 2) begin
      errors++;
      $display("FAIL default_bit_count: got %0d bit_ticks, expected 2", bts.size());
    end else begin
      checks++;
      if (bts[1] - bts[0] != EXP_BIT) begin
        errors++;
        $display("FAIL default_bit_period: got %0d cycles, expected %0d", bts[1] - bts[0], EXP_BIT);
      end
    end
  endtask

  task automatic test_load_run();
    tick_t e, got;
    int t, na, nb, stray;
    bit ok;
    apply_reset();
    bus.enable = 1'b1;
    last = cyc;
    push_ticks(3, EXP_INT, EXP_FRAC, 0, 1'b0);
    stray = 0;
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 1) begin
        // Two loads inside one period: the second overwrites the first.
        repeat (20) @(negedge Clk);
        bus.div_int = 16'd20; bus.div_frac = 4'd3; bus.div_load = 1'b1;
        @(negedge Clk);
        bus.div_load = 1'b0;
        repeat (5) @(negedge Clk);
        bus.div_int = 16'd10; bus.div_frac = 4'd0; bus.div_load = 1'b1;
        @(negedge Clk);
        bus.div_load = 1'b0;
        push_ticks(1, EXP_INT, EXP_FRAC, 0, 1'b1);
        acc_m = 0; cy_m = 1'b0;
        push_ticks(3, 10, 0, 0, 1'b0);
      end
      while (sb.size() != 0) begin
        e = sb.pop_front();
        wait_tick(200, t, ok, na, nb);
        stray += na;
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL load_run_tick: no os_tick in 200 cycles, expected gap %0d", e.gap);
        end else begin
          got.gap = 16'(t - last); got.idx = 8'(bus.tick_idx);
          got.bt = bus.bit_tick; got.ack = bus.div_ack;
          if (got !== e) begin
            errors++;
            $display("FAIL load_run_tick: got gap %0d idx %0d bit %0b ack %0b, expected gap %0d idx %0d bit %0b ack %0b",
                     got.gap, got.idx, got.bt, got.ack, e.gap, e.idx, e.bt, e.ack);
          end
          last = t;
        end
      end
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL load_run_stray_ack: got %0d acks off the boundary, expected 0", stray);
    end
  endtask

  task automatic test_load_idle();
    tick_t e, got;
    int t, na, nb;
    bit ok;
    apply_reset();
    bus.div_int = 16'd1; bus.div_frac = 4'(IDLE_FRAC); bus.div_load = 1'b1;
    @(negedge Clk);
    bus.div_load = 1'b0;
    checks++;
    if (bus.div_ack !== 1'b1) begin
      errors++;
      $display("FAIL load_idle_ack: got %0b, expected 1", bus.div_ack);
    end
    @(negedge Clk);
    checks++;
    if (bus.div_ack !== 1'b0) begin
      errors++;
      $display("FAIL load_idle_ack_single: got %0b, expected 0", bus.div_ack);
    end
    bus.enable = 1'b1;
    last = cyc;
    push_ticks(5, 2, IDLE_FRAC, 0, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      wait_tick(50, t, ok, na, nb);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL load_idle_tick: no os_tick in 50 cycles, expected gap %0d", e.gap);
      end else begin
        got.gap = 16'(t - last); got.idx = 8'(bus.tick_idx);
        got.bt = bus.bit_tick; got.ack = bus.div_ack;
        if (got !== e) begin
          errors++;
          $display("FAIL load_idle_tick: got gap %0d idx %0d bit %0b ack %0b, expected gap %0d idx %0d bit %0b ack %0b",
                   got.gap, got.idx, got.bt, got.ack, e.gap, e.idx, e.bt, e.ack);
        end
        last = t;
      end
    end
  endtask

  task automatic test_restart();
    tick_t e, got;
    int t, na, nb;
    bit ok;
    apply_reset();
    bus.enable = 1'b1;
    last = cyc;
    push_ticks(7, EXP_INT, EXP_FRAC, 0, 1'b0);
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 1) begin
        repeat (20) @(negedge Clk);
        bus.restart = 1'b1;
        @(negedge Clk);
        bus.restart = 1'b0;
        checks++;
        if ({bus.os_tick, bus.bit_tick, bus.tick_idx} !== 6'd0) begin
          errors++;
          $display("FAIL restart_clear: got os %0b bit %0b idx %0d, expected 0 0 0",
                   bus.os_tick, bus.bit_tick, bus.tick_idx);
        end
        last = cyc;
        model_reset();
        push_ticks(2, EXP_INT, EXP_FRAC, 0, 1'b0);
      end
      while (sb.size() != 0) begin
        e = sb.pop_front();
        wait_tick(200, t, ok, na, nb);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL restart_tick: no os_tick in 200 cycles, expected gap %0d", e.gap);
        end else begin
          got.gap = 16'(t - last); got.idx = 8'(bus.tick_idx);
          got.bt = bus.bit_tick; got.ack = bus.div_ack;
          if (got !== e) begin
            errors++;
            $display("FAIL restart_tick: got gap %0d idx %0d bit %0b ack %0b, expected gap %0d idx %0d bit %0b ack %0b",
                     got.gap, got.idx, got.bt, got.ack, e.gap, e.idx, e.bt, e.ack);
          end
          last = t;
        end
      end
    end
  endtask

  task automatic test_pause();
    tick_t e, got;
    int t, na, nb, seen;
    bit ok;
    apply_reset();
    bus.enable = 1'b1;
    last = cyc;
    push_ticks(2, EXP_INT, EXP_FRAC, 0, 1'b0);
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 1) begin
        repeat (20) @(negedge Clk);
        bus.enable = 1'b0;
        seen = 0;
        repeat (100) begin
          @(negedge Clk);
          if (bus.os_tick || bus.bit_tick) seen++;
        end
        bus.enable = 1'b1;
        checks++;
        if (seen != 0) begin
          errors++;
          $display("FAIL pause_quiet: got %0d ticks while disabled, expected 0", seen);
        end
        push_ticks(1, EXP_INT, EXP_FRAC, 100, 1'b0);
        push_ticks(1, EXP_INT, EXP_FRAC, 0, 1'b0);
      end
      while (sb.size() != 0) begin
        e = sb.pop_front();
        wait_tick(300, t, ok, na, nb);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL pause_tick: no os_tick in 300 cycles, expected gap %0d", e.gap);
        end else begin
          got.gap = 16'(t - last); got.idx = 8'(bus.tick_idx);
          got.bt = bus.bit_tick; got.ack = bus.div_ack;
          if (got !== e) begin
            errors++;
            $display("FAIL pause_tick: got gap %0d idx %0d bit %0b ack %0b, expected gap %0d idx %0d bit %0b ack %0b",
                     got.gap, got.idx, got.bt, got.ack, e.gap, e.idx, e.bt, e.ack);
          end
          last = t;
        end
      end
    end
  endtask

  task automatic test_reset_pend();
    tick_t e, got;
    int t, na, nb, stray;
    bit ok;
    int bts[$];
    apply_reset();
    bus.enable = 1'b1;
    last = cyc;
    push_ticks(1, EXP_INT, EXP_FRAC, 0, 1'b0);
    stray = 0;
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 1) begin
        repeat (10) @(negedge Clk);
        bus.div_int = 16'd10; bus.div_frac = 4'd0; bus.div_load = 1'b1;
        @(negedge Clk);
        bus.div_load = 1'b0;
        repeat (5) @(negedge Clk);
        Resetn = 1'b0;
        #1;
        checks++;
        if ({bus.os_tick, bus.bit_tick, bus.div_ack, bus.tick_idx} !== 7'd0) begin
          errors++;
          $display("FAIL reset_pend_async: got os %0b bit %0b ack %0b idx %0d, expected all 0",
                   bus.os_tick, bus.bit_tick, bus.div_ack, bus.tick_idx);
        end
        bus.enable = 1'b0;
        repeat (3) @(negedge Clk);
        Resetn = 1'b1;
        @(negedge Clk);
        model_reset();
        bus.enable = 1'b1;
        last = cyc;
        push_ticks(32, EXP_INT, EXP_FRAC, 0, 1'b0);
      end
      while (sb.size() != 0) begin
        e = sb.pop_front();
        wait_tick(200, t, ok, na, nb);
        if (phase == 1) stray += na;
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL reset_pend_tick: no os_tick in 200 cycles, expected gap %0d", e.gap);
        end else begin
          got.gap = 16'(t - last); got.idx = 8'(bus.tick_idx);
          got.bt = bus.bit_tick; got.ack = bus.div_ack;
          if (got !== e) begin
            errors++;
            $display("FAIL reset_pend_tick: got gap %0d idx %0d bit %0b ack %0b, expected gap %0d idx %0d bit %0b ack %0b",
                     got.gap, got.idx, got.bt, got.ack, e.gap, e.idx, e.bt, e.ack);
          end
          if (phase == 1 && bus.bit_tick) bts.push_back(t);
          last = t;
        end
      end
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL reset_pend_ack: got %0d div_ack pulses after reset, expected 0", stray);
    end
    checks++;
    if (bts.size() != 2) begin
      errors++;
      $display("FAIL reset_pend_bit_count: got %0d bit_ticks, expected 2", bts.size());
    end else begin
      checks++;
      if (bts[1] - bts[0] != EXP_BIT) begin
        errors++;
        $display("FAIL reset_pend_bit_period: got %0d cycles, expected %0d", bts[1] - bts[0], EXP_BIT);
      end
    end
  endtask

  initial begin
    bus.enable = 1'b0; bus.div_load = 1'b0; bus.restart = 1'b0;
    bus.div_int = '0; bus.div_frac = '0;
    test_reset();
    test_default_rate();
    test_load_run();
    test_load_idle();
    test_restart();
    test_pause();
    test_reset_pend();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
